restoring_divider_seq: RTL and testbench

//  Iterative unsigned restoring divider; the sequential stage that drives the ripple-borrow

---
 rtl/restoring_divider_seq.sv | 131 +++++++++++++
 tb/tb_restoring_divider_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/restoring_divider_seq.sv
// Purpose: iterative unsigned restoring divider, one trial subtraction per clock.
// Latency: WIDTH RUN cycles then a one-cycle DONE; divide-by-zero goes straight to DONE.
// Backpressure: start is ignored while busy; results hold until the next accepted start completes.

module fullsubtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module restoring_divider_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;

    logic [2*WIDTH:0] rq_sh;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   t;
    logic [WIDTH+1:0] brw;
    logic             commit;
    logic [WIDTH:0]   r_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             last_iter;
    logic             accept;

    // R[WIDTH] falls off the top of the shift; it is always zero here anyway.
    assign rq_sh = {r, q} << 1;
    assign r_sh  = rq_sh[2*WIDTH:WIDTH];
    assign d_ext = {1'b0, d};
    assign brw[0] = 1'b0;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
        fullsubtractor u_fs (
            .a    (r_sh[i]),
            .b    (d_ext[i]),
            .bin  (brw[i]),
            .diff (t[i]),
            .bout (brw[i+1])
        );
    end

    assign commit    = ~brw[WIDTH+1];
    assign r_nxt     = commit ? t : r_sh;
    assign q_nxt     = rq_sh[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, commit};
    assign last_iter = (cnt == CW'(1));

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                accept = start;
                if (start) state_nxt = (divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                accept    = start;
                state_nxt = IDLE;
                if (start) state_nxt = (divisor == '0) ? DONE : RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                r   <= '0;
                q   <= dividend;
                d   <= divisor;
                cnt <= CW'(WIDTH);
                // Zero divisor skips RUN entirely; result convention is all-ones / dividend.
                if (divisor == '0) begin
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end
            end else if (state == RUN) begin
                r   <= r_nxt;
                q   <= q_nxt;
                cnt <= cnt - CW'(1);
                if (last_iter) begin
                    quotient    <= q_nxt;
                    remainder   <= r_nxt[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_restoring_divider_seq.sv
// Directed and random checks of restoring_divider_seq at WIDTH=8.
module tb_restoring_divider_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    int vectors = 0;
    int errors  = 0;

    restoring_divider_seq #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present operands for exactly one sampling edge.
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        @(posedge clk); #1;
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count negedges until done; busy must be high on every cycle before it.
    task automatic wait_done(input string tag, input int exp_lat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!done) chk({tag, "_busy"}, busy, 1);
        end while (!done && n < 40);
        chk({tag, "_lat"}, n, exp_lat);
    endtask

    task automatic check_res(input string tag, input int eq, input int er, input int ez);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_lo"}, busy, 0);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dbz"}, div_by_zero, ez);
    endtask

    task automatic op(input string tag, input int a, input int b, input int eq, input int er,
                      input int ez, input int lat);
        launch(8'(a), 8'(b));
        wait_done(tag, lat);
        check_res(tag, eq, er, ez);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        // Reset state
        #12;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;

        op("t1_200_7", 200, 7, 28, 4, 0, 9);
        op("t2_255_1", 255, 1, 255, 0, 0, 9);
        op("t2_255_255", 255, 255, 1, 0, 0, 9);
        op("t2_5_9", 5, 9, 0, 5, 0, 9);
        op("t2_0_3", 0, 3, 0, 0, 0, 9);
        op("t3_77_0", 77, 0, 255, 77, 1, 1);
        op("t3_10_3", 10, 3, 3, 1, 0, 9);
        op("x_128_16", 128, 16, 8, 0, 0, 9);
        op("x_254_127", 254, 127, 2, 0, 0, 9);

        // Start pulse during RUN is ignored
        launch(8'd100, 8'd9);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
                if (!done) chk("t4_busy", busy, 1);
                if (n == 3) begin start = 1'b1; dividend = 8'd50; divisor = 8'd2; end
                if (n == 4) start = 1'b0;
            end while (!done && n < 40);
            chk("t4_lat", n, 9);
        end
        check_res("t4", 11, 1, 0);
        @(negedge clk);

        // Reset in the middle of RUN aborts the operation
        launch(8'd200, 8'd7);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_q", quotient, 0);
        chk("t5_r", remainder, 0);
        chk("t5_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            repeat (12) begin
                @(negedge clk);
                if (done) seen++;
            end
            chk("t5_no_done", seen, 0);
        end
        op("t5_9_2", 9, 2, 4, 1, 0, 9);

        // Back-to-back with start held across DONE
        @(posedge clk); #1;
        start = 1'b1; dividend = 8'd13; divisor = 8'd4;
        @(posedge clk); #1;
        wait_done("t6a", 9);
        check_res("t6a", 3, 1, 0);
        dividend = 8'd60; divisor = 8'd6;
        @(negedge clk);
        chk("t6_gap_done", done, 0);
        chk("t6_gap_busy", busy, 1);
        start = 1'b0;
        wait_done("t6b", 8);
        check_res("t6b", 10, 0, 0);
        @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            int a, b;
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            if (i % 50 == 0) b = 0;
            if (b == 0) op("rnd", a, b, 255, a, 1, 1);
            else        op("rnd", a, b, a / b, a % b, 0, 9);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
